// File: rtl/hex_display_writer_pkg.sv
// hex_display_pkg: shared types and constants for the HEX display writer.
//   state_t      - controller state encoding
//   SEG_DASH     - active-low dash pattern (overflow / invalid digit)
//   SEG_BLANK    - active-low all-off pattern (blanked leading zero)
//   NUM_DIGITS   - number of HEX PIOs driven
//   CONV_CYCLES  - double-dabble iterations (one per input bit)
//   dabble_adjust- add 3 to every BCD nibble >= 5
package hex_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam int NUM_DIGITS  = 6;
   localparam int CONV_CYCLES = 20;

   function automatic logic [23:0] dabble_adjust(input logic [23:0] bcd);
      logic [23:0] r;
      r = bcd;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd[4*k +: 4] >= 4'd5)
            r[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/hex_display_writer_if.sv
// hex_display_writer_if: Avalon-MM write-only master bundle.
//   avm_address     - byte address
//   avm_write       - write request
//   avm_writedata   - write data
//   avm_waitrequest - slave stall
// Modports: master (the writer), slave (interconnect / PIO side).
interface hex_display_writer_if;
   logic [31:0] avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;

   modport master (output avm_address, output avm_write, output avm_writedata,
                   input  avm_waitrequest);
   modport slave  (input  avm_address, input  avm_write, input  avm_writedata,
                   output avm_waitrequest);
endinterface

// File: rtl/hex_display_writer_seg7_encode.sv
// seg7_encode: decimal digit to active-low seven-segment pattern.
//   digit - 4-bit digit value; 10..15 produce a dash
//   seg   - bit0 = segment a ... bit6 = segment g, 0 = lit
module seg7_encode
   import hex_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0: seg = 7'h40;
         4'd1: seg = 7'h79;
         4'd2: seg = 7'h24;
         4'd3: seg = 7'h30;
         4'd4: seg = 7'h19;
         4'd5: seg = 7'h12;
         4'd6: seg = 7'h02;
         4'd7: seg = 7'h78;
         4'd8: seg = 7'h00;
         4'd9: seg = 7'h10;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/hex_display_writer.sv
// hex_display_writer: converts a 20-bit value to six decimal digits with a
// bit-serial double-dabble and writes one segment pattern to each HEX PIO.
//   clk, reset   - clock, asynchronous active-high reset
//   start, value - update request and value (captured on accepted start)
//   busy, done   - conversion/write in progress, one-cycle completion pulse
//   avm          - Avalon-MM master port (hex_display_writer_if.master)
//
// state   | meaning
// IDLE    | waiting for start
// CONVERT | one double-dabble step per cycle, CONV_CYCLES cycles
// WRITE   | writing digit dig to its HEX PIO, held through waitrequest
// DONE    | one-cycle done pulse, then back to IDLE
module hex_display_writer
   import hex_display_pkg::*;
#(
   parameter logic [31:0] HEX_BASE   = 32'h0000_0000,
   parameter logic [31:0] HEX_STRIDE = 32'h0000_0010,
   parameter bit          BLANK_LZ   = 1'b1
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [19:0]                 value,
   output logic                        busy,
   output logic                        done,
   hex_display_writer_if.master        avm
);

   state_t      state, state_nxt;
   logic [19:0] bin_q;
   logic [23:0] bcd_q;
   logic        ovf_q;
   logic [4:0]  cnt_q;
   logic [2:0]  dig_q;

   logic [23:0] bcd_sh;
   logic [3:0]  digit;
   logic [6:0]  seg_enc;
   logic [6:0]  seg;

   logic        accept;
   assign accept = (state == WRITE) && !avm.avm_waitrequest;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONVERT;
         CONVERT: if (cnt_q == 5'(CONV_CYCLES - 1)) state_nxt = WRITE;
         WRITE:   if (accept && dig_q == 3'(NUM_DIGITS - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_q <= '0;
         bcd_q <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
         dig_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               bin_q <= value;
               bcd_q <= '0;
               ovf_q <= (value > 20'd999999);
               cnt_q <= '0;
               dig_q <= '0;
            end
            CONVERT: begin
               {bcd_q, bin_q} <= {dabble_adjust(bcd_q), bin_q} << 1;
               cnt_q <= cnt_q + 5'd1;
            end
            WRITE: if (accept && dig_q != 3'(NUM_DIGITS - 1))
               dig_q <= dig_q + 3'd1;
            default: ;
         endcase
      end
   end

   // Shifting the current digit down to bit 0 also leaves all higher
   // digits in bcd_sh, so a zero result means this and every higher digit
   // are zero (leading-zero blanking).
   assign bcd_sh = bcd_q >> {dig_q, 2'b00};
   assign digit  = bcd_sh[3:0];

   seg7_encode u_enc (
      .digit (digit),
      .seg   (seg_enc)
   );

   always_comb begin
      seg = seg_enc;
      if (ovf_q)
         seg = SEG_DASH;
      else if (BLANK_LZ && dig_q != 3'd0 && bcd_sh == 24'd0)
         seg = SEG_BLANK;
   end

   always_comb begin
      busy              = (state == CONVERT) || (state == WRITE);
      done              = (state == DONE);
      avm.avm_write     = 1'b0;
      avm.avm_address   = '0;
      avm.avm_writedata = '0;
      if (state == WRITE) begin
         avm.avm_write     = 1'b1;
         avm.avm_address   = HEX_BASE + 32'(dig_q) * HEX_STRIDE;
         avm.avm_writedata = {25'b0, seg};
      end
   end

endmodule

// File: tb/tb_hex_display_writer.sv
module tb_hex_display_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [19:0] value;
   logic        busy;
   logic        done;

   hex_display_writer_if bus();

   hex_display_writer dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .value (value),
      .busy  (busy),
      .done  (done),
      .avm   (bus.master)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int         pow10   [6]  = '{1, 10, 100, 1000, 10000, 100000};
   logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int v, input int i);
      int d;
      if (v > 999999) return 32'h3F;
      if (i > 0 && v < pow10[i]) return 32'h7F;
      d = (v / pow10[i]) % 10;
      return {25'b0, seg_tbl[d]};
   endfunction

   function automatic logic [31:0] exp_addr(input int i);
      return 32'(i * 16);
   endfunction

   // One full display update. Returns at the negedge of the done cycle so the
   // next call's start lands in the cycle right after done.
   task automatic run(input int v, input int stall_dig, input int stall_n, input bit late);
      int cyc, nw, stalls, done_cyc;
      logic [31:0] ga [6];
      logic [31:0] gd [6];
      @(negedge clk);
      start = 1'b1;
      value = 20'(v);
      @(negedge clk);
      start = 1'b0;
      value = 20'($urandom);
      cyc = 1;
      nw = 0;
      stalls = stall_n;
      done_cyc = 0;
      check($sformatf("busy_c1 v=%0d", v), 32'(busy), 32'd1);
      while (cyc < 120) begin
         start = (late && cyc == 5);
         if (late && cyc == 5) value = 20'(v) ^ 20'h5A5A5;
         bus.avm_waitrequest = 1'b0;
         if (done) begin
            done_cyc = cyc;
            check($sformatf("busy_at_done v=%0d", v), 32'(busy), 32'd0);
            check($sformatf("write_at_done v=%0d", v), 32'(bus.avm_write), 32'd0);
            break;
         end else if (bus.avm_write) begin
            if (nw == stall_dig && stalls > 0) begin
               bus.avm_waitrequest = 1'b1;
               stalls--;
               check($sformatf("stall_addr v=%0d", v), bus.avm_address, exp_addr(nw));
               check($sformatf("stall_data v=%0d", v), bus.avm_writedata, exp_data(v, nw));
            end else begin
               if (nw < 6) begin
                  ga[nw] = bus.avm_address;
                  gd[nw] = bus.avm_writedata;
               end
               nw++;
            end
         end else if (!busy) begin
            check($sformatf("busy_early_low v=%0d c=%0d", v, cyc), 32'(busy), 32'd1);
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check($sformatf("done_cycle v=%0d", v), 32'(done_cyc), 32'(27 + stall_n));
      check($sformatf("num_writes v=%0d", v), 32'(nw), 32'd6);
      for (int i = 0; i < 6 && i < nw; i++) begin
         check($sformatf("addr%0d v=%0d", i, v), ga[i], exp_addr(i));
         check($sformatf("data%0d v=%0d", i, v), gd[i], exp_data(v, i));
      end
   endtask

   task automatic reset_mid_write();
      @(negedge clk);
      start = 1'b1;
      value = 20'd654321;
      @(negedge clk);
      start = 1'b0;
      repeat (23) @(negedge clk);
      check("rst_pre_write", 32'(bus.avm_write), 32'd1);
      check("rst_pre_addr", bus.avm_address, 32'h30);
      reset = 1'b1;
      #1;
      check("rst_write", 32'(bus.avm_write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", bus.avm_address, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_no_done", 32'(done), 32'd0);
      end
      reset = 1'b0;
   endtask

   initial begin
      int v, cat;
      reset = 1'b1;
      start = 1'b0;
      value = '0;
      bus.avm_waitrequest = 1'b0;
      #12;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_write", 32'(bus.avm_write), 32'd0);
      check("reset_addr", bus.avm_address, 32'd0);
      check("reset_data", bus.avm_writedata, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run(123456, 0, 0, 1'b0);
      run(0, 0, 0, 1'b0);
      run(1005, 0, 0, 1'b0);
      run(1000000, 0, 0, 1'b0);
      run(999999, 0, 0, 1'b0);
      run(123456, 2, 3, 1'b0);
      run(314159, 0, 0, 1'b1);
      reset_mid_write();
      run(987654, 0, 0, 1'b0);

      for (int n = 0; n < 16; n++) begin
         cat = int'($urandom_range(0, 3));
         case (cat)
            0:       v = int'($urandom_range(0, 99));
            1:       v = int'($urandom_range(0, 999999));
            2:       v = int'($urandom_range(1000000, 1048575));
            default: v = pow10[$urandom_range(0, 5)] - int'($urandom_range(0, 1));
         endcase
         run(v, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
